// File: rtl/dp_demod.sv
// rtl/dp_demod.sv - AM envelope / FM zero-crossing period demodulator
// Four register stages: capture, rectify, state update, output select.
module dp_demod #(
    parameter int HYST = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_data,
    input  logic        val_in,
    input  logic        c_fm_am,
    input  logic [15:0] per_nom,
    input  logic [3:0]  g_fm,
    input  logic [3:0]  k_am,
    output logic [15:0] o_data,
    output logic        val_out,
    output logic        o_lock
);
    typedef enum logic [1:0] {SEEK_LOW, SEEK_HIGH, TRACK_LOW, TRACK_HIGH} fsm_t;

    localparam logic signed [15:0] HYST_POS = 16'(HYST);
    localparam logic signed [15:0] HYST_NEG = -HYST_POS;

    logic signed [15:0] x1, x2, neg_x1;
    logic [14:0]        ax1, ax2;
    logic               m1, m2, m3;
    logic               v1, v2, v3;

    fsm_t               state, state_b, state_n;
    logic [23:0]        acc, acc_b, acc_n;
    logic [15:0]        cnt, cnt_b, cnt_n;
    logic [15:0]        fm_est, est_b, est_n;
    logic               lock_b, lock_n, mode_q, mode_chg;
    logic signed [24:0] acc_diff, acc_step, acc_sum;
    logic [16:0]        cnt_p1, per2;
    logic signed [16:0] per_diff;
    logic signed [31:0] per_shift;
    logic [15:0]        per_sat;
    logic               is_low, is_high, crossing, timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            x1 <= '0;
            m1 <= 1'b0;
        end else begin
            v1 <= val_in;
            if (val_in) begin
                x1 <= i_data;
                m1 <= c_fm_am;
            end
        end
    end

    // -32768 has no positive counterpart, so it rectifies to full scale.
    assign neg_x1 = -x1;
    always_comb begin
        ax1 = 15'(x1);
        if (x1 == 16'sh8000)
            ax1 = 15'h7FFF;
        else if (x1[15])
            ax1 = 15'(neg_x1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2  <= 1'b0;
            x2  <= '0;
            ax2 <= '0;
            m2  <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                x2  <= x1;
                ax2 <= ax1;
                m2  <= m1;
            end
        end
    end

    // A mode change restarts both detectors from a clean state before this sample.
    assign mode_chg = (m2 != mode_q);
    assign acc_b    = mode_chg ? '0 : acc;
    assign cnt_b    = mode_chg ? '0 : cnt;
    assign est_b    = mode_chg ? '0 : fm_est;
    assign lock_b   = mode_chg ? 1'b0 : o_lock;
    assign state_b  = mode_chg ? SEEK_LOW : state;

    assign acc_diff = $signed({2'b00, ax2, 8'h00}) - $signed({1'b0, acc_b});
    assign acc_step = acc_diff >>> k_am;
    assign acc_sum  = $signed({1'b0, acc_b}) + acc_step;
    assign acc_n    = 24'(acc_sum);

    assign is_high  = (x2 >= HYST_POS);
    assign is_low   = (x2 <= HYST_NEG);
    assign cnt_p1   = {1'b0, cnt_b} + 17'd1;
    assign per2     = {per_nom, 1'b0};
    assign crossing = (state_b == TRACK_HIGH) && is_high;
    assign timeout  = (cnt_p1 >= per2);

    assign per_diff  = $signed({1'b0, per_nom}) - $signed(cnt_p1);
    assign per_shift = {{15{per_diff[16]}}, per_diff} <<< g_fm;

    always_comb begin
        per_sat = 16'(per_shift);
        if (per_shift > 32'sd32767)
            per_sat = 16'h7FFF;
        else if (per_shift < -32'sd32768)
            per_sat = 16'h8000;
    end

    always_comb begin
        state_n = state_b;
        cnt_n   = cnt_b;
        est_n   = est_b;
        lock_n  = lock_b;
        case (state_b)
            SEEK_LOW: begin
                if (is_low)
                    state_n = SEEK_HIGH;
            end
            SEEK_HIGH: begin
                if (is_high) begin
                    state_n = TRACK_LOW;
                    cnt_n   = '0;
                end
            end
            default: begin
                if (crossing) begin
                    state_n = TRACK_LOW;
                    cnt_n   = '0;
                    est_n   = per_sat;
                    lock_n  = 1'b1;
                end else if (timeout) begin
                    state_n = SEEK_LOW;
                    cnt_n   = '0;
                    est_n   = '0;
                    lock_n  = 1'b0;
                end else begin
                    cnt_n = cnt_p1[16] ? 16'hFFFF : 16'(cnt_p1);
                    if ((state_b == TRACK_LOW) && is_low)
                        state_n = TRACK_HIGH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= SEEK_LOW;
        else if (v2)
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            cnt    <= '0;
            fm_est <= '0;
            o_lock <= 1'b0;
            mode_q <= 1'b0;
            v3     <= 1'b0;
            m3     <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                acc    <= acc_n;
                cnt    <= cnt_n;
                fm_est <= est_n;
                o_lock <= lock_n;
                mode_q <= m2;
                m3     <= m2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_out <= 1'b0;
            o_data  <= '0;
        end else begin
            val_out <= v3;
            if (v3)
                o_data <= m3 ? fm_est : acc[23:8];
        end
    end
endmodule

// File: tb/tb_dp_demod.sv
// tb/tb_dp_demod.sv - randomized self-checking bench for dp_demod
module tb_dp_demod;
    localparam int HYST = 256;
    localparam int PH_WAIT_LOW  = 0;
    localparam int PH_WAIT_HIGH = 1;
    localparam int PH_MEAS_LOW  = 2;
    localparam int PH_MEAS_HIGH = 3;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic [15:0] i_data  = '0;
    logic        val_in  = 1'b0;
    logic        c_fm_am = 1'b0;
    logic [15:0] per_nom = 16'd8;
    logic [3:0]  g_fm    = 4'd4;
    logic [3:0]  k_am    = 4'd0;
    logic [15:0] o_data;
    logic        val_out;
    logic        o_lock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          exp_cyc[$];
    logic [15:0] exp_data[$];
    bit          exp_lock[$];
    int          obs_cyc[$];
    logic [15:0] obs_data[$];
    bit          obs_lock[$];
    bit          lock_prev = 1'b0;

    int m_acc, m_cnt, m_est, m_phase;
    bit m_lock, m_mode;

    dp_demod #(.HYST(HYST)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .val_in  (val_in),
        .c_fm_am (c_fm_am),
        .per_nom (per_nom),
        .g_fm    (g_fm),
        .k_am    (k_am),
        .o_data  (o_data),
        .val_out (val_out),
        .o_lock  (o_lock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Lock is taken one cycle before val_out, when it reflects that sample's update.
    always @(negedge clk) begin
        if (val_out) begin
            obs_cyc.push_back(cyc);
            obs_data.push_back(o_data);
            obs_lock.push_back(lock_prev);
        end
        lock_prev = o_lock;
    end

    task automatic model_reset();
        m_acc   = 0;
        m_cnt   = 0;
        m_est   = 0;
        m_phase = PH_WAIT_LOW;
        m_lock  = 1'b0;
        m_mode  = 1'b0;
    endtask

    task automatic model_step(input int x, input bit m, output logic [15:0] d, output bit l);
        int ax, diff, div, p, per;
        longint prod;
        per = int'(per_nom);
        if (m != m_mode) begin
            m_acc   = 0;
            m_cnt   = 0;
            m_est   = 0;
            m_lock  = 1'b0;
            m_phase = PH_WAIT_LOW;
        end
        m_mode = m;
        ax = (x < 0) ? -x : x;
        if (ax > 32767) ax = 32767;
        div  = 1 << k_am;
        diff = ax * 256 - m_acc;
        m_acc = m_acc + ((diff >= 0) ? diff / div : -((-diff + div - 1) / div));
        if (m_phase == PH_WAIT_LOW) begin
            if (x <= -HYST) m_phase = PH_WAIT_HIGH;
        end else if (m_phase == PH_WAIT_HIGH) begin
            if (x >= HYST) begin
                m_phase = PH_MEAS_LOW;
                m_cnt   = 0;
            end
        end else if (m_phase == PH_MEAS_HIGH && x >= HYST) begin
            p    = m_cnt + 1;
            prod = longint'(per - p) * (longint'(1) << g_fm);
            if (prod > 32767) m_est = 32767;
            else if (prod < -32768) m_est = -32768;
            else m_est = int'(prod);
            m_lock  = 1'b1;
            m_cnt   = 0;
            m_phase = PH_MEAS_LOW;
        end else if (m_cnt + 1 >= 2 * per) begin
            m_phase = PH_WAIT_LOW;
            m_cnt   = 0;
            m_est   = 0;
            m_lock  = 1'b0;
        end else begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_phase == PH_MEAS_LOW && x <= -HYST) m_phase = PH_MEAS_HIGH;
        end
        d = m ? 16'(m_est) : 16'(m_acc / 256);
        l = m_lock;
    endtask

    task automatic drive(input bit v, input int x, input bit m);
        logic [15:0] d;
        bit l;
        @(negedge clk);
        val_in  = v;
        i_data  = 16'(x);
        c_fm_am = m;
        if (v && rst) begin
            model_step(x, m, d, l);
            exp_cyc.push_back(cyc + 1);
            exp_data.push_back(d);
            exp_lock.push_back(l);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)));
    endtask

    function automatic int sq(input int i, input int p);
        int a;
        a = int'($urandom_range(HYST, 20000));
        return ((i % p) < p / 2) ? a : -a;
    endfunction

    task automatic clear_queues();
        exp_cyc.delete();
        exp_data.delete();
        exp_lock.delete();
        obs_cyc.delete();
        obs_data.delete();
        obs_lock.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        val_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        clear_queues();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'(i % 2 == 0), int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)));
            checks++;
            if (o_data !== 16'd0 || val_out !== 1'b0 || o_lock !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got data=%0d val=%0b lock=%0b want 0 0 0", i, o_data, val_out, o_lock);
            end
        end
        @(negedge clk);
        rst    = 1'b1;
        val_in = 1'b0;
        model_reset();
        clear_queues();
        idle(2);
        drive(1'b1, 12000, 1'b0);
        drive(1'b1, -7000, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        val_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (obs_data.size() != 0) begin
            failures++;
            $display("FAIL reset_flush: got %0d outputs want 0", obs_data.size());
        end
        rst = 1'b1;
        model_reset();
        clear_queues();
        k_am = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) drive(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0);
        idle(6);
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL reset_count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_cyc[i] - exp_cyc[i] != 3 || obs_lock[i] !== exp_lock[i]) begin
                failures++;
                $display("FAIL reset_sample[%0d]: got data=%0d lat=%0d lock=%0b want data=%0d lat=3 lock=%0b",
                         i, $signed(obs_data[i]), obs_cyc[i] - exp_cyc[i], obs_lock[i], $signed(exp_data[i]), exp_lock[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_am();
        do_reset();
        k_am = 4'd1;
        for (int i = 0; i < 6; i++) drive(1'b1, 1000, 1'b0);
        idle(4);
        k_am = 4'd0;
        for (int i = 0; i < 3; i++) drive(1'b1, -32768, 1'b0);
        idle(4);
        k_am = 4'($urandom_range(0, 15));
        for (int i = 0; i < 30; i++) drive(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0);
        idle(6);
        checks++;
        if (obs_data.size() < 7 || obs_data[0] !== 16'd500 || obs_data[1] !== 16'd750 ||
            obs_data[2] !== 16'd875 || obs_data[3] !== 16'd937) begin
            failures++;
            $display("FAIL am_step_k1: got %0d outputs, first four differ from 500 750 875 937", obs_data.size());
        end
        checks++;
        if (obs_data.size() < 7 || obs_data[6] !== 16'd32767) begin
            failures++;
            $display("FAIL am_full_scale: got %0d want 32767", (obs_data.size() < 7) ? -1 : int'(obs_data[6]));
        end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL am_count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_cyc[i] - exp_cyc[i] != 3 || obs_lock[i] !== exp_lock[i]) begin
                failures++;
                $display("FAIL am_sample[%0d]: got data=%0d lat=%0d lock=%0b want data=%0d lat=3 lock=%0b",
                         i, $signed(obs_data[i]), obs_cyc[i] - exp_cyc[i], obs_lock[i], $signed(exp_data[i]), exp_lock[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_fm_nominal();
        do_reset();
        per_nom = 16'd8;
        g_fm    = 4'd4;
        for (int i = 0; i < 48; i++) drive(1'b1, sq(i, 8), 1'b1);
        for (int i = 0; i < 48; i++) drive(1'b1, sq(i, 6), 1'b1);
        for (int i = 0; i < 60; i++) drive(1'b1, sq(i, 10), 1'b1);
        idle(6);
        checks++;
        if (obs_data.size() < 156 || obs_lock[15] !== 1'b0 || obs_lock[16] !== 1'b1) begin
            failures++;
            $display("FAIL fm_lock_rise: got %0d outputs, lock at 15/16 not 0 then 1", obs_data.size());
        end
        checks++;
        if (obs_data.size() < 156 || obs_data[47] !== 16'd0 || obs_data[95] !== 16'd32 || obs_data[155] !== 16'hFFE0) begin
            failures++;
            $display("FAIL fm_periods: got %0d outputs, want 0 / 32 / -32 at periods 8 / 6 / 10", obs_data.size());
        end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL fm_count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_cyc[i] - exp_cyc[i] != 3 || obs_lock[i] !== exp_lock[i]) begin
                failures++;
                $display("FAIL fm_sample[%0d]: got data=%0d lat=%0d lock=%0b want data=%0d lat=3 lock=%0b",
                         i, $signed(obs_data[i]), obs_cyc[i] - exp_cyc[i], obs_lock[i], $signed(exp_data[i]), exp_lock[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_timeout();
        do_reset();
        per_nom = 16'd8;
        g_fm    = 4'd4;
        for (int i = 0; i < 40; i++) drive(1'b1, sq(i, 8), 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, int'($urandom_range(0, 2 * HYST - 2)) - (HYST - 1), 1'b1);
        for (int i = 0; i < 24; i++) drive(1'b1, sq(i, 8), 1'b1);
        idle(6);
        checks++;
        if (obs_data.size() < 84 || obs_lock[47] !== 1'b1 || obs_lock[48] !== 1'b0 || obs_data[48] !== 16'd0) begin
            failures++;
            $display("FAIL timeout_edge: got %0d outputs, lock not 1 then 0 at 16 samples after last event", obs_data.size());
        end
        checks++;
        if (obs_data.size() < 84 || obs_lock[75] !== 1'b0 || obs_lock[76] !== 1'b1) begin
            failures++;
            $display("FAIL relock: got %0d outputs, lock not rising at sample 76", obs_data.size());
        end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL timeout_count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_cyc[i] - exp_cyc[i] != 3 || obs_lock[i] !== exp_lock[i]) begin
                failures++;
                $display("FAIL timeout_sample[%0d]: got data=%0d lat=%0d lock=%0b want data=%0d lat=3 lock=%0b",
                         i, $signed(obs_data[i]), obs_cyc[i] - exp_cyc[i], obs_lock[i], $signed(exp_data[i]), exp_lock[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_saturation();
        do_reset();
        per_nom = 16'd8;
        g_fm    = 4'd15;
        for (int i = 0; i < 48; i++) drive(1'b1, sq(i, 6), 1'b1);
        for (int i = 0; i < 72; i++) drive(1'b1, sq(i, 12), 1'b1);
        idle(6);
        checks++;
        if (obs_data.size() < 120 || obs_data[47] !== 16'h7FFF || obs_data[119] !== 16'h8000) begin
            failures++;
            $display("FAIL fm_saturate: got %0d outputs, want 32767 then -32768", obs_data.size());
        end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL sat_count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_cyc[i] - exp_cyc[i] != 3 || obs_lock[i] !== exp_lock[i]) begin
                failures++;
                $display("FAIL sat_sample[%0d]: got data=%0d lat=%0d lock=%0b want data=%0d lat=3 lock=%0b",
                         i, $signed(obs_data[i]), obs_cyc[i] - exp_cyc[i], obs_lock[i], $signed(exp_data[i]), exp_lock[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_mode_switch();
        bit m;
        int p;
        do_reset();
        per_nom = 16'd8;
        g_fm    = 4'd4;
        k_am    = 4'd4;
        for (int i = 0; i < 30; i++) drive(1'b1, sq(i, 6), 1'b1);
        drive(1'b1, 0, 1'b0);
        drive(1'b1, -1000, 1'b1);
        idle(4);
        per_nom = 16'($urandom_range(4, 20));
        g_fm    = 4'($urandom_range(0, 15));
        k_am    = 4'($urandom_range(0, 15));
        p = int'(per_nom) + int'($urandom_range(0, 4)) - 2;
        m = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) m = ~m;
            drive(1'b1, m ? sq(i, p) : int'($urandom_range(0, 65535)) - 32768, m);
            idle(int'($urandom_range(0, 3)));
        end
        idle(6);
        checks++;
        if (obs_data.size() < 32 || obs_data[29] !== 16'd32 || obs_data[30] !== 16'd0 ||
            obs_data[31] !== 16'd0 || obs_lock[31] !== 1'b0) begin
            failures++;
            $display("FAIL mode_clear: got %0d outputs, state not cleared on mode flips", obs_data.size());
        end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL mode_count: got %0d val_out want %0d val_in", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_cyc[i] - exp_cyc[i] != 3 || obs_lock[i] !== exp_lock[i]) begin
                failures++;
                $display("FAIL mode_sample[%0d]: got data=%0d lat=%0d lock=%0b want data=%0d lat=3 lock=%0b",
                         i, $signed(obs_data[i]), obs_cyc[i] - exp_cyc[i], obs_lock[i], $signed(exp_data[i]), exp_lock[i]);
            end
        end
        clear_queues();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_am();
        test_fm_nominal();
        test_timeout();
        test_saturation();
        test_mode_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dp_demod.md
# dp_demod

AM/FM demodulator, the receive-side counterpart of the DDS-based modulator datapath. Takes the modulated 16-bit sample stream, produces the recovered baseband with the same `val_in`/`val_out` strobe protocol. AM uses a rectifier plus first-order IIR envelope detector. FM uses a hysteretic zero-crossing period counter, whose output is the deviation from a programmable nominal carrier period.

## Interface
- `HYST`, 256: crossing-detector hysteresis threshold, in LSBs of `i_data` (positive, < 32768).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_data` in 16: signed modulated sample.
- `val_in` in 1: `i_data` valid strobe; one sample per asserted cycle, gaps allowed.
- `c_fm_am` in 1: mode select, sampled with `val_in`. 1 = FM, 0 = AM.
- `per_nom` in 16: nominal carrier period in samples, unsigned, ≥ 2.
- `g_fm` in 4: FM output gain, as a left-shift amount.
- `k_am` in 4: AM smoothing shift, 0..15.
- `o_data` out 16: signed demodulated sample.
- `val_out` out 1: `o_data` valid strobe.
- `o_lock` out 1: FM has a valid period measurement.

## Operation
- **Reset:** `rst`=0 clears `o_data`=0, `val_out`=0, `o_lock`=0, all pipeline registers, `acc`=0, `cnt`=0, `fm_est`=0, FSM=SEEK_LOW, and the previous-mode register `mode_q`=0.
- **Stage 1** (on `val_in`):
  - Register `x`=`i_data`, `m`=`c_fm_am`.
  - Compute `ax`=|x|, saturated so that -32768 gives 32767.
- **Mode change:** when stage-1 `m` ≠ `mode_q`, the stage-2 update of that sample first clears `acc`, `cnt`, `fm_est`, `o_lock` and sets FSM=SEEK_LOW. It then processes the sample normally. `mode_q` ← `m`.
- **Stage 2, AM path** (runs every valid sample, both modes):
  - `acc` is 24-bit unsigned Q16.8.
  - `acc` ← `acc` + (((`ax`<<8) − `acc`) >>> `k_am`), using signed 25-bit arithmetic.
  - Envelope `env` = `acc`[23:8], always in 0..32767.
- **Stage 2, FM FSM** (advances only on valid samples):
  - SEEK_LOW → SEEK_HIGH when `x` ≤ −`HYST`.
  - SEEK_HIGH → TRACK_LOW when `x` ≥ +`HYST`; `cnt` ← 0.
  - TRACK_LOW → TRACK_HIGH when `x` ≤ −`HYST`.
  - TRACK_HIGH → TRACK_LOW when `x` ≥ +`HYST`. This is a crossing event.
- **Counter `cnt`** (16-bit, saturating at 0xFFFF): increments on every valid sample in TRACK_*.
- **Crossing event:**
  - Period P = `cnt`+1, i.e. samples since the previous event, inclusive of the current one.
  - `cnt` ← 0.
  - `fm_est` ← sat16((`per_nom` − P) <<< `g_fm`), using a signed 17-bit difference before the shift; `o_lock` ← 1.
- **Timeout:** in TRACK_*, when `cnt`+1 ≥ 2·`per_nom` (17-bit compare) without an event:
  - FSM ← SEEK_LOW, `cnt` ← 0, `fm_est` ← 0, `o_lock` ← 0.
  - If the same sample also produces an event, the event wins.
- **Stage 3:** `o_data` ← `m` ? `fm_est` (value after this sample's update) : `env`.
- **Saturation:** sat16 clamps to [−32768, 32767]. All arithmetic is two's complement.

## Timing
- `val_out` = `val_in` delayed exactly 3 cycles, independent of mode, FSM state or gaps. `o_data` is aligned with it.
- Fixed latency: a sample accepted at edge N appears on `o_data` at edge N+3.
- `o_data` holds its value between `val_out` pulses.
- No back-pressure. Back-to-back `val_in` is accepted every cycle.
- `o_lock` updates at the same edge as stage 2, i.e. one cycle before the `o_data` that reflects it.
- `per_nom`, `g_fm`, `k_am` may change at any time and take effect at the next stage-2 update. Quasi-static use is expected.
- Asynchronous reset mid-stream discards every in-flight sample. No `val_out` appears for samples accepted within 3 cycles before reset.

## Test plan
- **Reset:** hold `rst`=0 with `val_in` toggling → `o_data`=0, `val_out`=0, `o_lock`=0 throughout. After release, the first `val_out` appears 3 cycles after the first `val_in`.
- **AM step:** AM, `k_am`=0, constant `i_data`=−32768 → first `o_data`=32767 at 3-cycle latency. With `k_am`=1, constant 1000 → `o_data` = 500, 750, 875, 937, …
- **FM nominal:** FM, `per_nom`=8, `g_fm`=4, square wave ±1000 with period 8 →
  - `o_lock` rises on the first event after SEEK completes;
  - `o_data`=0 thereafter.
  - Same setup with period 6 → `o_data`=32.
  - With period 10 → `o_data`=−32.
- **Hysteresis/timeout:** FM locked at period 8, then `i_data` noise within ±200 (`HYST`=256) → no events; after 16 samples from the last event `o_lock`=0 and `o_data`=0. Restoring the square wave → relock after one full seek cycle.
- **Saturation:** `per_nom`=8, `g_fm`=15, period 6 → `o_data`=32767.
- **Mode switch / gaps:** flip `c_fm_am` mid-stream with random 0–3 cycle `val_in` gaps →
  - the first sample in the new mode sees cleared state;
  - `val_out` count equals `val_in` count;
  - every `val_out` is exactly 3 cycles after its `val_in`.
